// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = a - b).
// Alignment and normalization each shift one bit per cycle; specials resolve at capture.
module fp_sub_seq #(
  parameter int unsigned GUARD_BITS = 2,
  parameter int unsigned MAX_ALIGN  = 24 + GUARD_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int unsigned SW = 24 + GUARD_BITS;
  localparam logic [31:0] QNan = 32'h7FC0_0000;

  typedef enum logic [2:0] {StIdle, StAlign, StSub, StNorm, StPack, StDone} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      big_q, big_d, small_q, small_d;
  logic [SW:0]        mag_q, mag_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [7:0]         diff_q, diff_d;
  logic               sign_big_q, sign_big_d, sign_small_q, sign_small_d, sign_q, sign_d;
  logic [31:0]        result_q, result_d;

  // Subtraction is addition with the sign of b inverted.
  logic        a_sgn, b_sgn;
  logic [7:0]  a_exp, b_exp;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [SW-1:0] a_sig, b_sig;
  logic [SW:0] sum, sub_mag;
  logic        sub_sgn;

  assign a_sgn  = a[31];
  assign b_sgn  = ~b[31];
  assign a_exp  = a[30:23];
  assign b_exp  = b[30:23];
  assign a_nan  = (a_exp == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan  = (b_exp == 8'hFF) && (b[22:0] != 23'h0);
  assign a_inf  = (a_exp == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf  = (b_exp == 8'hFF) && (b[22:0] == 23'h0);
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_sig  = {1'b1, a[22:0], {GUARD_BITS{1'b0}}};
  assign b_sig  = {1'b1, b[22:0], {GUARD_BITS{1'b0}}};
  assign sum    = {1'b0, big_q} + {1'b0, small_q};

  always_comb begin
    sub_mag = '0;
    sub_sgn = 1'b0;
    if (sign_big_q == sign_small_q) begin
      sub_mag = sum;
      sub_sgn = sign_big_q;
    end else if (big_q > small_q) begin
      sub_mag = {1'b0, big_q - small_q};
      sub_sgn = sign_big_q;
    end else if (small_q > big_q) begin
      sub_mag = {1'b0, small_q - big_q};
      sub_sgn = sign_small_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    big_d        = big_q;
    small_d      = small_q;
    mag_d        = mag_q;
    exp_d        = exp_q;
    diff_d       = diff_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    sign_d       = sign_q;
    result_d     = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StDone;
          if (a_nan || b_nan)       result_d = QNan;
          else if (a_inf && b_inf)  result_d = (a_sgn == b_sgn) ? {a_sgn, 8'hFF, 23'h0} : QNan;
          else if (a_inf)           result_d = a;
          else if (b_inf)           result_d = {b_sgn, b[30:0]};
          else if (a_zero && b_zero) result_d = 32'h0;
          else if (a_zero)          result_d = {b_sgn, b[30:0]};
          else if (b_zero)          result_d = a;
          else begin
            state_d = StAlign;
            if (a_exp >= b_exp) begin
              big_d        = a_sig;
              small_d      = b_sig;
              exp_d        = signed'({2'b00, a_exp});
              diff_d       = a_exp - b_exp;
              sign_big_d   = a_sgn;
              sign_small_d = b_sgn;
            end else begin
              big_d        = b_sig;
              small_d      = a_sig;
              exp_d        = signed'({2'b00, b_exp});
              diff_d       = b_exp - a_exp;
              sign_big_d   = b_sgn;
              sign_small_d = a_sgn;
            end
          end
        end
      end
      StAlign: begin
        if (diff_q > 8'(MAX_ALIGN)) begin
          small_d = '0;
          diff_d  = '0;
          state_d = StSub;
        end else if (diff_q == 8'd0) begin
          state_d = StSub;
        end else begin
          small_d = small_q >> 1;
          diff_d  = diff_q - 8'd1;
          if (diff_q == 8'd1) state_d = StSub;
        end
      end
      StSub: begin
        mag_d  = sub_mag;
        sign_d = sub_sgn;
        // Already-normalized results skip NORM entirely.
        if (sub_mag == '0)                      state_d = StPack;
        else if (sub_mag[SW] || !sub_mag[SW-1]) state_d = StNorm;
        else                                    state_d = StPack;
      end
      StNorm: begin
        if (mag_q[SW]) begin
          mag_d   = mag_q >> 1;
          exp_d   = exp_q + 10'sd1;
          state_d = StPack;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 10'sd1;
          if (mag_q[SW-2]) state_d = StPack;
        end
      end
      StPack: begin
        state_d = StDone;
        if (mag_q == '0)            result_d = 32'h0;
        else if (exp_q >= 10'sd255) result_d = {sign_q, 8'hFF, 23'h0};
        else if (exp_q <= 10'sd0)   result_d = 32'h0;
        else                        result_d = {sign_q, exp_q[7:0], mag_q[SW-2 -: 23]};
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      big_q        <= '0;
      small_q      <= '0;
      mag_q        <= '0;
      exp_q        <= '0;
      diff_q       <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sign_q       <= 1'b0;
      result_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      big_q        <= big_d;
      small_q      <= small_d;
      mag_q        <= mag_d;
      exp_q        <= exp_d;
      diff_q       <= diff_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      sign_q       <= sign_d;
      result_q     <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed self-checking bench for fp_sub_seq: values, latency, specials and handshake.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
    string       name;
  } vec_t;

  fp_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] va, vb, vr, input int vl, input string nm);
    vec_t v;
    v.a = va; v.b = vb; v.r = vr; v.lat = vl; v.name = nm;
    return v;
  endfunction

  // Drives one operation from idle; latency counts the capture edge as cycle 1.
  task automatic do_op(input logic [31:0] av, bv, output logic [31:0] res, output int lat);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h4040_0000; b = 32'h3F80_0000;
    repeat (2) @(posedge clk);
    #1;
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    asserts++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h want=00000000", result); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors(input string group);
    vec_t v[$];
    logic [31:0] res;
    int lat;
    if (group == "basic") begin
      v.push_back(mk(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, "3_minus_1"));
      v.push_back(mk(32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4, "1_minus_3"));
      v.push_back(mk(32'h4100_0000, 32'h3F80_0000, 32'h40E0_0000, 7, "8_minus_1"));
    end else if (group == "cancel") begin
      v.push_back(mk(32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, "1_minus_0p75"));
      v.push_back(mk(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4, "1_minus_1"));
      v.push_back(mk(32'h0080_0000, 32'h00C0_0000, 32'h0000_0000, 5, "underflow"));
    end else if (group == "special") begin
      v.push_back(mk(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1, "inf_minus_inf"));
      v.push_back(mk(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, "nan_a"));
      v.push_back(mk(32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000, 1, "nan_b"));
      v.push_back(mk(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 1, "zero_minus_1"));
      v.push_back(mk(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1, "1_minus_zero"));
      v.push_back(mk(32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1, "1_minus_inf"));
      v.push_back(mk(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1, "neginf_minus_1"));
      v.push_back(mk(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1, "zero_minus_zero"));
    end else begin
      v.push_back(mk(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 5, "overflow"));
      v.push_back(mk(32'h4B80_0000, 32'h3380_0000, 32'h4B80_0000, 4, "large_gap"));
    end
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, res, lat);
      asserts++;
      if (res !== v[i].r) begin
        fails++;
        $display("FAIL %s result got=%h want=%h", v[i].name, res, v[i].r);
      end
      asserts++;
      if (lat !== v[i].lat) begin
        fails++;
        $display("FAIL %s latency got=%0d want=%0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    a = 32'h3F80_0000; b = 32'h3F40_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;          // captured, now ALIGN
    in_valid = 1'b0;
    repeat (2) @(posedge clk);   // SUB, then first NORM cycle
    #1;
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after got=%b want=0", busy); end
    repeat (10) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    asserts++; if (seen !== 0) begin fails++; $display("FAIL mid_no_out_valid got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back;
    int n;
    a = 32'h4040_0000; b = 32'h3F80_0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'h3F80_0000; b = 32'h4040_0000;   // next operand held while busy
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    asserts++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_wait out_valid timeout"); end
    for (int i = 0; i < 10; i++) begin
      asserts++;
      if (result !== 32'h4000_0000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d result=%h in_ready=%b out_valid=%b want 40000000/0/1",
                 i, result, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release out_valid got=%b want=0", out_valid); end
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;          // held operand captured here
    a = 32'h4000_0000; b = 32'hBF80_0000;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    asserts++; if (result !== 32'hC000_0000) begin fails++; $display("FAIL b2b_first got=%h want=C0000000", result); end
    @(posedge clk); #1;          // DONE -> IDLE, next operand still valid
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    asserts++; if (result !== 32'h4040_0000) begin fails++; $display("FAIL b2b_second got=%h want=40400000", result); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    test_reset;
    test_vectors("basic");
    test_vectors("cancel");
    test_vectors("special");
    test_vectors("overflow");
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/fp_sub_seq.md
Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor: out = a - b. It is the inverse-operation companion to the combinational fp adder.
- Iterative datapath: alignment shifts 1 bit/cycle and normalization shifts 1 bit/cycle, trading latency for area.
- Sits between an operand source and a result sink, both using valid/ready handshakes.
- Adds the special-case handling the combinational adder lacks: zero, inf, NaN, overflow and underflow.

Parameters:
- GUARD_BITS, 2: extra LSBs kept below the 24-bit significand during align/subtract. Bits shifted past them are discarded.
- MAX_ALIGN, 26: exponent difference above which the smaller operand is zeroed in a single cycle (= 24 + GUARD_BITS).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  32  minuend, {sign, exp[7:0], frac[22:0]}.
- b  input  32  subtrahend, same format.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- result  output  32  a - b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - in_ready = 1; out_valid = 0; result = 32'h0; busy = 0.
  - Reset mid-operation abandons the operation; no result is produced.
- FSM states: IDLE, ALIGN, SUB, NORM, PACK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a and b, and flip b's sign (subtraction becomes addition with sign of b inverted). Go to ALIGN.
  - If a special case applies, load result and go directly to DONE.
- Operand rules:
  - exp == 0 is treated as zero (denormals flushed).
  - A normal operand's significand is {1, frac, GUARD_BITS zeros}, 26 bits total.
- Special cases, resolved at capture, in priority order:
  1. Either operand NaN (exp = 255, frac != 0) -> 32'h7FC00000.
  2. inf - inf with same sign -> 32'h7FC00000.
  3. Exactly one operand inf -> that inf, with its effective sign.
  4. Both operands zero -> 32'h00000000.
  5. Exactly one operand zero -> the other operand, with its effective sign.
- ALIGN:
  - Swap operands so the larger exponent is in the "big" slot; result exponent = larger exponent.
  - Shift the smaller significand right 1 bit per cycle until the exponents are equal.
  - If the difference exceeds MAX_ALIGN, zero the smaller significand in one cycle.
  - Difference 0 spends exactly one cycle in ALIGN.
- SUB (1 cycle):
  - Same effective signs: 27-bit sum.
  - Different effective signs: |big - small|. Sign is that of the larger magnitude; ties (exactly equal) give +0.
- NORM:
  - Sum carry out: shift right 1 and increment exponent (1 cycle).
  - Otherwise, while the MSB is 0 and the value is nonzero: shift left 1 and decrement exponent, 1 cycle per bit.
  - Zero magnitude goes straight to PACK as +0.
- PACK (1 cycle):
  - Truncate guard bits (round toward zero).
  - Exponent >= 255 -> signed inf.
  - Exponent <= 0 -> +0 (underflow flush).
  - Otherwise {sign, exp, significand[24:2] excluding the hidden bit}. Go to DONE.
- DONE:
  - out_valid = 1; result held stable.
  - On out_ready: out_valid drops next cycle and state returns to IDLE. in_ready rises in that same cycle.
  - No new operand is accepted while out_valid = 1.
- Latency, from capture edge to out_valid = 1 cycle capture + max(1, d) align + 1 sub + n norm + 1 pack, where d = exponent difference and n = normalization shifts. Special cases: out_valid on the cycle after capture.
- Back-pressure: holding out_ready low indefinitely keeps result stable. in_valid during that time is ignored and not lost; the source must hold it.
- Arithmetic width: 8-bit exponent handled in a 10-bit signed register so overflow and underflow are detectable.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 1, out_valid = 0, result = 0. Reset asserted mid-NORM -> IDLE with no out_valid pulse.
- Basic values (out_ready = 1):
  - a = 40400000 (3.0), b = 3F800000 (1.0) -> result 40000000 after capture + 1 align + 1 sub + 0 norm + 1 pack.
  - a = 3F800000, b = 40400000 -> result C0000000.
- Cancellation and normalization:
  - a = 3F800000, b = 3F400000 (1.0 - 0.75) -> result 3E800000, with NORM occupying 2 cycles.
  - a = b = 3F800000 -> result 00000000.
- Special values:
  - a = b = 7F800000 -> 7FC00000.
  - a = 7FC00001, any b -> 7FC00000.
  - a = 00000000, b = 3F800000 -> BF800000.
- Overflow and large exponent gap:
  - a = 7F7FFFFF, b = FF7FFFFF -> 7F800000.
  - a = 4B800000, b = 33800000 (difference > MAX_ALIGN) -> 4B800000 with a single ALIGN cycle.
- Handshake: out_ready held low 10 cycles -> result stable and in_ready = 0 throughout. out_ready pulsed -> in_ready = 1 next cycle, and back-to-back operands are accepted.
